lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencing controller between the ALU stage and the data-memory bus. It captures the memory operation produced by the ALU and runs a request/grant/read-valid handshake with the data memory. Load data is lane-extracted and sign/zero-extended. The block also owns the register-file write port, merging ALU results and load results, and stalls the pipeline while a memory access is outstanding.

## Interface
- cDataWidth, 32, data/address width (only 32 supported)
- cRegAddrWidth, 5, register index width
- cTimeout, 255, max cycles in REQ or WAIT_RD before abort (1..255)

- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-low
- iMemRead  in  1  load request from ALU (one-cycle pulse)
- iMemWrite  in  1  store request from ALU (one-cycle pulse)
- iMemAddr  in  32  byte address
- iMemData  in  32  store data (rs2)
- iMemOpType  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- iMemRdAddr  in  5  load destination register
- iRegDv / iRegAddr / iRegData  in  1/5/32  ALU register result
- oStall  out  1  pipeline hold; high whenever state != IDLE
- oBusReq / oBusWe  out  1/1  bus request / write enable
- oBusAddr  out  32  word address ({addr[31:2],2'b00})
- oBusWdata / oBusBe  out  32/4  lane-replicated write data / byte enables
- iBusGnt  in  1  request accepted this cycle
- iBusRvalid / iBusRdata  in  1/32  read response
- oRfWe / oRfAddr / oRfData  out  1/5/32  register-file write port
- oMisaligned  out  1  one-cycle pulse, misaligned access dropped
- oBusErr  out  1  one-cycle pulse, timeout abort

## Operation
- States: IDLE, REQ, WAIT_RD, WB.
- IDLE: iMemRead or iMemWrite captures addr, data, opType, rdAddr, and direction. If both are high, the operation is treated as a read.
- Alignment check at capture:
  - H/HU/SH require addr[0]=0.
  - W requires addr[1:0]=00.
  - On violation: oMisaligned pulses next cycle, no bus access, state stays IDLE.
- Aligned op → REQ.
  - Hold oBusReq, oBusWe, oBusAddr, oBusWdata, oBusBe stable until iBusGnt.
  - Store on grant → IDLE.
  - Load on grant → WAIT_RD.
- WAIT_RD: on iBusRvalid, register extracted data → WB. A response arriving in the grant cycle itself is ignored.
- Load extraction:
  - B/BU select byte addr[1:0]; H/HU select half addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Store lanes:
  - SB: data[7:0] replicated ×4, Be = 0001 << addr[1:0].
  - SH: data[15:0] ×2, Be = 0011 << {addr[1],1'b0}.
  - SW: Be = 1111.
- WB: oRfWe=1, oRfAddr=rdAddr, oRfData=load data, then → IDLE. If rdAddr=0, oRfWe stays 0 (bus access still performed).
- ALU results:
  - When not in WB: iRegDv registers to oRfWe/oRfAddr/oRfData next cycle; iRegAddr=0 suppresses oRfWe.
  - iRegDv during WB: stored in a one-entry holding buffer and written the cycle after WB; load has priority.
  - A second iRegDv while the buffer is full is a protocol violation and is not supported.
- Timeout:
  - Cycle counter clears on entering REQ and WAIT_RD.
  - Reaching cTimeout → oBusErr pulse, oBusReq drops, → IDLE, no register write.
- Reset (any time, including mid-transaction):
  - All outputs 0, state IDLE, holding buffer empty, counter 0.
  - oBusReq falls asynchronously.

## Timing
- Capture at edge T0. oStall and oBusReq are high from T1.
- Store, grant at T1: oStall low at T2.
- Load, grant at T1, iBusRvalid at T2: oRfWe high in T3, oStall low at T4.
- ALU-only write: 1-cycle latency from iRegDv to oRfWe.
- oMisaligned and oBusErr are single-cycle pulses, registered.
- Upstream presents new memory ops only when oStall=0. Inputs are ignored while oStall=1.

## Test plan
- LB at addr 0x103, rdata 0x80AA55CC → oRfData 0xFFFFFF80 written to rdAddr 5 at T3; LBU same → 0x00000080.
- SH at addr 0x202, data 0x1234BEEF, grant delayed 3 cycles → oBusAddr 0x200, Be 1100, Wdata 0xBEEFBEEF held stable; oStall low the cycle after grant.
- LW at 0x101 → oMisaligned pulse, no oBusReq, no oRfWe. LH at 0x102 → accepted.
- iRegDv (x7 = 0x55) in the same cycle the load WB (x3) occurs → x3 written first, x7 written the next cycle; no loss.
- Load with no iBusRvalid and cTimeout=8 → oBusErr pulse 8 cycles after entering WAIT_RD, return to IDLE, no write; load to x0 → bus access performed, no oRfWe.
- iRst asserted low while in WAIT_RD → oBusReq, oStall, oRfWe at 0 immediately; a later iBusRvalid after release is ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: captures ALU memory ops, runs the data-memory
// req/gnt/rvalid handshake and owns the merged register-file write port.
module lsu_ctrl #(
    parameter int unsigned cDataWidth    = 32,
    parameter int unsigned cRegAddrWidth = 5,
    parameter int unsigned cTimeout      = 255
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iMemRead,
    input  logic                     iMemWrite,
    input  logic [cDataWidth-1:0]    iMemAddr,
    input  logic [cDataWidth-1:0]    iMemData,
    input  logic [2:0]               iMemOpType,
    input  logic [cRegAddrWidth-1:0] iMemRdAddr,
    input  logic                     iRegDv,
    input  logic [cRegAddrWidth-1:0] iRegAddr,
    input  logic [cDataWidth-1:0]    iRegData,
    output logic                     oStall,
    output logic                     oBusReq,
    output logic                     oBusWe,
    output logic [cDataWidth-1:0]    oBusAddr,
    output logic [cDataWidth-1:0]    oBusWdata,
    output logic [3:0]               oBusBe,
    input  logic                     iBusGnt,
    input  logic                     iBusRvalid,
    input  logic [cDataWidth-1:0]    iBusRdata,
    output logic                     oRfWe,
    output logic [cRegAddrWidth-1:0] oRfAddr,
    output logic [cDataWidth-1:0]    oRfData,
    output logic                     oMisaligned,
    output logic                     oBusErr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_WB} state_e;

    localparam logic [7:0] cTmoLast = 8'(cTimeout - 1);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     bus_req_q, bus_req_d;
    logic                     bus_we_q, bus_we_d;
    logic [cDataWidth-1:0]    bus_addr_q, bus_addr_d;
    logic [cDataWidth-1:0]    bus_wdata_q, bus_wdata_d;
    logic [3:0]               bus_be_q, bus_be_d;
    logic [2:0]               op_q, op_d;
    logic [1:0]               alo_q, alo_d;
    logic [cRegAddrWidth-1:0] rd_q, rd_d;
    logic                     rf_we_q, rf_we_d;
    logic [cRegAddrWidth-1:0] rf_addr_q, rf_addr_d;
    logic [cDataWidth-1:0]    rf_data_q, rf_data_d;
    logic                     hb_valid_q, hb_valid_d;
    logic [cRegAddrWidth-1:0] hb_addr_q, hb_addr_d;
    logic [cDataWidth-1:0]    hb_data_q, hb_data_d;
    logic                     mis_q, mis_d;
    logic                     err_q, err_d;

    logic                     cap_misaligned;
    logic                     load_wr;
    logic                     alu_v;
    logic [cDataWidth-1:0]    rd_shift;
    logic [cDataWidth-1:0]    ld_data;

    always_comb begin
        cap_misaligned = 1'b0;
        case (iMemOpType[1:0])
            2'b00:   cap_misaligned = 1'b0;
            2'b01:   cap_misaligned = iMemAddr[0];
            default: cap_misaligned = |iMemAddr[1:0];
        endcase
    end

    // Shifting the addressed lane down to bit 0 covers both byte and halfword selects.
    always_comb begin
        rd_shift = iBusRdata >> {alo_q, 3'b000};
        ld_data  = iBusRdata;
        case (op_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'h000000, rd_shift[7:0]};
            3'b101:  ld_data = {16'h0000, rd_shift[15:0]};
            default: ld_data = iBusRdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        op_d        = op_q;
        alo_d       = alo_q;
        rd_d        = rd_q;
        rf_we_d     = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        hb_valid_d  = hb_valid_q;
        hb_addr_d   = hb_addr_q;
        hb_data_d   = hb_data_q;
        mis_d       = 1'b0;
        err_d       = 1'b0;
        load_wr     = 1'b0;
        alu_v       = iRegDv && (iRegAddr != '0);

        case (state_q)
            S_IDLE: begin
                if (iMemRead || iMemWrite) begin
                    if (cap_misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        cnt_d      = '0;
                        bus_req_d  = 1'b1;
                        bus_we_d   = ~iMemRead;
                        bus_addr_d = {iMemAddr[cDataWidth-1:2], 2'b00};
                        op_d       = iMemOpType;
                        alo_d      = iMemAddr[1:0];
                        rd_d       = iMemRdAddr;
                        case (iMemOpType[1:0])
                            2'b00: begin
                                bus_wdata_d = {4{iMemData[7:0]}};
                                bus_be_d    = 4'b0001 << iMemAddr[1:0];
                            end
                            2'b01: begin
                                bus_wdata_d = {2{iMemData[15:0]}};
                                bus_be_d    = 4'b0011 << {iMemAddr[1], 1'b0};
                            end
                            default: begin
                                bus_wdata_d = iMemData;
                                bus_be_d    = 4'b1111;
                            end
                        endcase
                    end
                end
            end
            S_REQ: begin
                if (iBusGnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = bus_we_q ? S_IDLE : S_WAIT_RD;
                end else if (cnt_q == cTmoLast) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_RD: begin
                if (iBusRvalid) begin
                    load_wr = 1'b1;
                    state_d = S_WB;
                end else if (cnt_q == cTmoLast) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The load result is registered on entry to WB so oRfWe is high during WB itself;
        // an ALU result colliding with it (or with the buffer drain) is parked one cycle.
        if (load_wr && (rd_q != '0)) begin
            rf_we_d   = 1'b1;
            rf_addr_d = rd_q;
            rf_data_d = ld_data;
            if (alu_v) begin
                hb_valid_d = 1'b1;
                hb_addr_d  = iRegAddr;
                hb_data_d  = iRegData;
            end
        end else if (hb_valid_q) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = hb_addr_q;
            rf_data_d  = hb_data_q;
            hb_valid_d = alu_v;
            if (alu_v) begin
                hb_addr_d = iRegAddr;
                hb_data_d = iRegData;
            end
        end else if (alu_v) begin
            rf_we_d   = 1'b1;
            rf_addr_d = iRegAddr;
            rf_data_d = iRegData;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            op_q        <= '0;
            alo_q       <= '0;
            rd_q        <= '0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            hb_valid_q  <= 1'b0;
            hb_addr_q   <= '0;
            hb_data_q   <= '0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            op_q        <= op_d;
            alo_q       <= alo_d;
            rd_q        <= rd_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            hb_valid_q  <= hb_valid_d;
            hb_addr_q   <= hb_addr_d;
            hb_data_q   <= hb_data_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
        end
    end

    assign oStall      = (state_q != S_IDLE);
    assign oBusReq     = bus_req_q;
    assign oBusWe      = bus_we_q;
    assign oBusAddr    = bus_addr_q;
    assign oBusWdata   = bus_wdata_q;
    assign oBusBe      = bus_be_q;
    assign oRfWe       = rf_we_q;
    assign oRfAddr     = rf_addr_q;
    assign oRfData     = rf_data_q;
    assign oMisaligned = mis_q;
    assign oBusErr     = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized load/store/ALU traffic.
module tb_lsu_ctrl;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iMemRead, iMemWrite;
    logic [31:0] iMemAddr, iMemData;
    logic [2:0]  iMemOpType;
    logic [4:0]  iMemRdAddr;
    logic        iRegDv;
    logic [4:0]  iRegAddr;
    logic [31:0] iRegData;
    logic        oStall, oBusReq, oBusWe;
    logic [31:0] oBusAddr, oBusWdata;
    logic [3:0]  oBusBe;
    logic        iBusGnt, iBusRvalid;
    logic [31:0] iBusRdata;
    logic        oRfWe;
    logic [4:0]  oRfAddr;
    logic [31:0] oRfData;
    logic        oMisaligned, oBusErr;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    always #5 iClk = ~iClk;

    lsu_ctrl #(.cDataWidth(32), .cRegAddrWidth(5), .cTimeout(8)) dut (
        .iClk(iClk), .iRst(iRst),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemAddr(iMemAddr),
        .iMemData(iMemData), .iMemOpType(iMemOpType), .iMemRdAddr(iMemRdAddr),
        .iRegDv(iRegDv), .iRegAddr(iRegAddr), .iRegData(iRegData),
        .oStall(oStall), .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr),
        .oBusWdata(oBusWdata), .oBusBe(oBusBe), .iBusGnt(iBusGnt),
        .iBusRvalid(iBusRvalid), .iBusRdata(iBusRdata),
        .oRfWe(oRfWe), .oRfAddr(oRfAddr), .oRfData(oRfData),
        .oMisaligned(oMisaligned), .oBusErr(oBusErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Register-file writes must appear in arrival order, load before ALU on a tie.
    always @(negedge iClk) begin
        if (iRst === 1'b1 && oRfWe === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rf_unexpected: observed x%0d=0x%08h expected no write", oRfAddr, oRfData);
            end
            if (exp_q.size() != 0) begin
                checks++;
                assert ({oRfAddr, oRfData} === exp_q[0]) else begin
                    errors++;
                    $error("FAIL rf_write: observed x%0d=0x%08h expected x%0d=0x%08h",
                           oRfAddr, oRfData, exp_q[0][36:32], exp_q[0][31:0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic int unsigned op_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] addr);
        return (addr % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned n = op_size(op);
        logic [31:0] v, mask;
        if (n == 4) return rdata;
        v    = rdata >> (8 * (addr % 4));
        mask = 32'((64'd1 << (8 * n)) - 1);
        v    = v & mask;
        if (!op[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
        int unsigned n = op_size(op);
        int unsigned off = addr % 4;
        logic [3:0] be = '0;
        for (int unsigned i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] data);
        int unsigned n = op_size(op);
        logic [31:0] w = '0;
        for (int unsigned i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] op, input logic [4:0] rda);
        iMemRead = rd; iMemWrite = wr; iMemAddr = addr; iMemData = data;
        iMemOpType = op; iMemRdAddr = rda;
        tick();
        iMemRead = 1'b0; iMemWrite = 1'b0; iMemAddr = $urandom; iMemData = $urandom;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] rda,
                           input logic [31:0] rdata, input int gd, input int rvd,
                           input bit alu_en, input logic [4:0] alu_a, input logic [31:0] alu_d);
        logic [31:0] exp_v = ref_load(op, addr, rdata);
        bit alu_w = alu_en && (alu_a != 0);
        mem_op(1'b1, 1'b0, addr, 32'h0, op, rda);
        chk("ld_stall", oStall, 1); chk("ld_req", oBusReq, 1);
        chk("ld_we", oBusWe, 0); chk("ld_addr", oBusAddr, addr & 32'hFFFF_FFFC);
        repeat (gd) begin tick(); chk("ld_req_hold", oBusReq, 1); end
        iBusGnt = 1'b1; iBusRvalid = 1'($urandom_range(0, 1)); iBusRdata = $urandom;
        tick();
        iBusGnt = 1'b0; iBusRvalid = 1'b0;
        chk("ld_req_drop", oBusReq, 0); chk("ld_stall_wait", oStall, 1);
        repeat (rvd) tick();
        iBusRvalid = 1'b1; iBusRdata = rdata;
        if (rda != 0) exp_q.push_back({rda, exp_v});
        if (alu_en) begin
            iRegDv = 1'b1; iRegAddr = alu_a; iRegData = alu_d;
            if (alu_w) exp_q.push_back({alu_a, alu_d});
        end
        tick();
        iBusRvalid = 1'b0; iBusRdata = $urandom; iRegDv = 1'b0;
        chk("ld_wb_stall", oStall, 1);
        chk("ld_wb_we", oRfWe, (rda != 0) || alu_w);
        if (rda != 0) begin
            chk("ld_wb_addr", oRfAddr, rda); chk("ld_wb_data", oRfData, exp_v);
        end
        tick();
        chk("ld_done_stall", oStall, 0);
        chk("ld_after_we", oRfWe, alu_w && (rda != 0));
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] op, input int gd);
        mem_op(1'b0, 1'b1, addr, data, op, 5'd0);
        chk("st_stall", oStall, 1); chk("st_req", oBusReq, 1); chk("st_we", oBusWe, 1);
        chk("st_addr", oBusAddr, addr & 32'hFFFF_FFFC);
        chk("st_be", oBusBe, ref_be(op, addr)); chk("st_wdata", oBusWdata, ref_wdata(op, data));
        for (int i = 0; i < gd; i++) begin
            tick();
            chk("st_hold_req", oBusReq, 1); chk("st_hold_addr", oBusAddr, addr & 32'hFFFF_FFFC);
            chk("st_hold_be", oBusBe, ref_be(op, addr));
            chk("st_hold_wdata", oBusWdata, ref_wdata(op, data));
        end
        iBusGnt = 1'b1;
        tick();
        iBusGnt = 1'b0;
        chk("st_done_stall", oStall, 0); chk("st_req_drop", oBusReq, 0);
    endtask

    task automatic do_mis(input logic rd, input logic [31:0] addr, input logic [2:0] op);
        mem_op(rd, ~rd, addr, $urandom, op, 5'd9);
        chk("mis_pulse", oMisaligned, 1); chk("mis_stall", oStall, 0); chk("mis_req", oBusReq, 0);
        tick();
        chk("mis_pulse_end", oMisaligned, 0); chk("mis_rfwe", oRfWe, 0);
    endtask

    task automatic do_alu(input logic [4:0] a, input logic [31:0] d);
        iRegDv = 1'b1; iRegAddr = a; iRegData = d;
        if (a != 0) exp_q.push_back({a, d});
        tick();
        iRegDv = 1'b0;
        chk("alu_we", oRfWe, a != 0);
    endtask

    initial begin
        logic [2:0] ld_ops[5];
        logic [2:0] st_ops[3];
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_ops = '{3'b000, 3'b001, 3'b010};
        iRst = 1'b0; iMemRead = 0; iMemWrite = 0; iMemAddr = 0; iMemData = 0;
        iMemOpType = 0; iMemRdAddr = 0; iRegDv = 0; iRegAddr = 0; iRegData = 0;
        iBusGnt = 0; iBusRvalid = 0; iBusRdata = 0;
        repeat (2) tick();
        chk("rst_stall", oStall, 0); chk("rst_req", oBusReq, 0); chk("rst_rfwe", oRfWe, 0);
        chk("rst_mis", oMisaligned, 0); chk("rst_err", oBusErr, 0);
        @(negedge iClk) iRst = 1'b1;
        tick();

        do_load(32'h103, 3'b000, 5'd5, 32'h80AA55CC, 0, 0, 1'b0, 5'd0, 32'h0);
        do_load(32'h103, 3'b100, 5'd5, 32'h80AA55CC, 0, 0, 1'b0, 5'd0, 32'h0);
        do_store(32'h202, 32'h1234BEEF, 3'b001, 3);
        do_mis(1'b1, 32'h101, 3'b010);
        do_load(32'h102, 3'b001, 5'd6, 32'hC0DE8001, 1, 1, 1'b0, 5'd0, 32'h0);
        do_load(32'h008, 3'b010, 5'd3, 32'hDEADBEEF, 0, 0, 1'b1, 5'd7, 32'h55);
        do_load(32'h010, 3'b010, 5'd0, 32'h12345678, 0, 1, 1'b0, 5'd0, 32'h0);
        do_alu(5'd0, 32'hFFFF);
        do_alu(5'd12, 32'hA5A5A5A5);

        // Load with no response: abort on the 8th cycle in WAIT_RD.
        mem_op(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 5'd9);
        iBusGnt = 1'b1; tick(); iBusGnt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(); chk("to_rd_noerr", oBusErr, 0); chk("to_rd_stall", oStall, 1);
        end
        tick();
        chk("to_rd_err", oBusErr, 1); chk("to_rd_idle", oStall, 0);
        tick();
        chk("to_rd_err_end", oBusErr, 0);

        // Store never granted: request abort.
        mem_op(1'b0, 1'b1, 32'h44, 32'h1, 3'b010, 5'd0);
        for (int i = 0; i < 7; i++) begin tick(); chk("to_rq_req", oBusReq, 1); end
        tick();
        chk("to_rq_err", oBusErr, 1); chk("to_rq_req_drop", oBusReq, 0); chk("to_rq_idle", oStall, 0);
        tick();

        // Reset while requesting: oBusReq falls without a clock edge.
        mem_op(1'b1, 1'b0, 32'h80, 32'h0, 3'b010, 5'd4);
        chk("rq_rst_pre", oBusReq, 1);
        #2 iRst = 1'b0;
        #1 chk("rq_rst_req", oBusReq, 0); chk("rq_rst_stall", oStall, 0);
        @(negedge iClk) iRst = 1'b1;
        tick();

        // Reset in WAIT_RD with an ALU write on the port; late response ignored.
        mem_op(1'b1, 1'b0, 32'h84, 32'h0, 3'b010, 5'd4);
        iBusGnt = 1'b1; iRegDv = 1'b1; iRegAddr = 5'd8; iRegData = 32'h77;
        tick();
        iBusGnt = 1'b0; iRegDv = 1'b0;
        chk("wr_rst_pre_we", oRfWe, 1); chk("wr_rst_pre_stall", oStall, 1);
        #2 iRst = 1'b0;
        #1 chk("wr_rst_we", oRfWe, 0); chk("wr_rst_stall", oStall, 0); chk("wr_rst_req", oBusReq, 0);
        @(negedge iClk) iRst = 1'b1;
        tick();
        iBusRvalid = 1'b1; iBusRdata = 32'hBAD0BAD0;
        tick();
        iBusRvalid = 1'b0;
        chk("late_rv_we", oRfWe, 0); chk("late_rv_stall", oStall, 0);
        tick();

        for (int n = 0; n < 60; n++) begin
            int unsigned kind = $urandom_range(0, 3);
            logic [31:0] addr = $urandom;
            logic [2:0]  op;
            if (kind == 0) begin
                op = ld_ops[$urandom_range(0, 4)];
                if (ref_mis(op, addr)) do_mis(1'b1, addr, op);
                else do_load(addr, op, 5'($urandom), $urandom, $urandom_range(0, 3),
                             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
            end else if (kind == 1) begin
                op = st_ops[$urandom_range(0, 2)];
                if (ref_mis(op, addr)) do_mis(1'b0, addr, op);
                else do_store(addr, $urandom, op, $urandom_range(0, 3));
            end else begin
                do_alu(5'($urandom), $urandom);
            end
        end
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
